// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    MEM_DONE
  } ctrl_state_e;

  // Winning stall/flush source for a cycle; selects which debug counter advances.
  typedef enum logic [1:0] {
    HAZ_NONE,
    HAZ_DATA,
    HAZ_BRANCH,
    HAZ_MEM
  } haz_src_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the stall/flush controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             fwd_en;
  logic [4:0]       src1;
  logic [4:0]       src2;
  logic             two_src;
  logic [4:0]       exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic [4:0]       mem_dest;
  logic             mem_wb_en;
  logic             mem_req;
  logic             br_taken;
  logic             sram_ready;
  logic             pc_freeze;
  logic             if_id_freeze;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             id_ex_freeze;
  logic             ex_mem_freeze;
  logic             mem_wb_freeze;
  logic             sram_start;
  logic             mem_timeout;
  logic [CNT_W-1:0] hazard_stalls;
  logic [CNT_W-1:0] mem_stalls;

  modport master (
    output fwd_en, src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, mem_req, br_taken, sram_ready,
    input  pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, id_ex_freeze,
           ex_mem_freeze, mem_wb_freeze, sram_start, mem_timeout,
           hazard_stalls, mem_stalls
  );

  modport slave (
    input  fwd_en, src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, mem_req, br_taken, sram_ready,
    output pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, id_ex_freeze,
           ex_mem_freeze, mem_wb_freeze, sram_start, mem_timeout,
           hazard_stalls, mem_stalls
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational RAW/load-use detector for the instruction sitting in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       fwd_en,
  input  logic [4:0] src1,
  input  logic [4:0] src2,
  input  logic       two_src,
  input  logic [4:0] exe_dest,
  input  logic       exe_wb_en,
  input  logic       exe_mem_r_en,
  input  logic [4:0] mem_dest,
  input  logic       mem_wb_en,
  output logic       hazard
);
  logic exe_match;
  logic mem_match;

  // r0 is hard-wired, so a write to it never creates a dependency.
  assign exe_match = (exe_dest != REG_ZERO) &&
                     ((exe_dest == src1) || (two_src && (exe_dest == src2)));
  assign mem_match = (mem_dest != REG_ZERO) &&
                     ((mem_dest == src1) || (two_src && (mem_dest == src2)));

  // With forwarding only a load result in EXE is still unavailable.
  assign hazard = fwd_en ? (exe_mem_r_en && exe_match)
                         : ((exe_wb_en && exe_match) || (mem_wb_en && mem_match));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: data hazards, taken branches and the
// multi-cycle SRAM handshake, plus saturating stall-cycle counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d, wait_cnt_inc;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  hazard_stalls_q, hazard_stalls_d;
  logic [CNT_W-1:0]  mem_stalls_q, mem_stalls_d;
  logic              data_hazard;
  logic              mem_busy;
  haz_src_e          haz_src;

  hazard_detect u_hazard_detect (
    .fwd_en       (bus.fwd_en),
    .src1         (bus.src1),
    .src2         (bus.src2),
    .two_src      (bus.two_src),
    .exe_dest     (bus.exe_dest),
    .exe_wb_en    (bus.exe_wb_en),
    .exe_mem_r_en (bus.exe_mem_r_en),
    .mem_dest     (bus.mem_dest),
    .mem_wb_en    (bus.mem_wb_en),
    .hazard       (data_hazard)
  );

  assign mem_busy     = ((state_q == IDLE) && bus.mem_req) || (state_q == MEM_WAIT);
  assign wait_cnt_inc = wait_cnt_q + WAIT_W'(1);

  always_comb begin
    haz_src = HAZ_NONE;
    if (mem_busy)         haz_src = HAZ_MEM;
    else if (bus.br_taken) haz_src = HAZ_BRANCH;
    else if (data_hazard) haz_src = HAZ_DATA;
  end

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    unique case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (bus.mem_req) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        wait_cnt_d = wait_cnt_inc;
        if (bus.sram_ready) begin
          state_d = MEM_DONE;
        end else if (wait_cnt_inc == WAIT_W'(MEM_TIMEOUT)) begin
          mem_timeout_d = 1'b1;
          state_d       = MEM_DONE;
        end
      end
      MEM_DONE: begin
        // Any mem_req here belongs to the next instruction; IDLE picks it up.
        wait_cnt_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hazard_stalls_d = hazard_stalls_q;
    mem_stalls_d    = mem_stalls_q;
    if ((haz_src == HAZ_DATA) && !(&hazard_stalls_q)) hazard_stalls_d = hazard_stalls_q + 1'b1;
    if ((haz_src == HAZ_MEM) && !(&mem_stalls_q))     mem_stalls_d    = mem_stalls_q + 1'b1;
  end

  // NOTE: sequential state is updated with <= so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      wait_cnt_q      <= '0;
      mem_timeout_q   <= 1'b0;
      hazard_stalls_q <= '0;
      mem_stalls_q    <= '0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      mem_timeout_q   <= mem_timeout_d;
      hazard_stalls_q <= hazard_stalls_d;
      mem_stalls_q    <= mem_stalls_d;
    end
  end

  // Zero-latency controls; forced low while reset is held.
  always_comb begin
    bus.pc_freeze     = 1'b0;
    bus.if_id_freeze  = 1'b0;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_flush   = 1'b0;
    bus.id_ex_freeze  = 1'b0;
    bus.ex_mem_freeze = 1'b0;
    bus.mem_wb_freeze = 1'b0;
    bus.sram_start    = 1'b0;
    if (rst) begin
      unique case (haz_src)
        HAZ_MEM: begin
          bus.pc_freeze     = 1'b1;
          bus.if_id_freeze  = 1'b1;
          bus.id_ex_freeze  = 1'b1;
          bus.ex_mem_freeze = 1'b1;
          bus.mem_wb_freeze = 1'b1;
          bus.sram_start    = (state_q == IDLE);
        end
        HAZ_BRANCH: begin
          bus.if_id_flush = 1'b1;
          bus.id_ex_flush = 1'b1;
        end
        HAZ_DATA: begin
          bus.pc_freeze    = 1'b1;
          bus.if_id_freeze = 1'b1;
          bus.id_ex_flush  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_timeout   = mem_timeout_q;
  assign bus.hazard_stalls = hazard_stalls_q;
  assign bus.mem_stalls    = mem_stalls_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for the combinational
// hazard/branch paths, hand-written sequences for SRAM, timeout and reset.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_haz = 0;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_frz, ifid_frz, ifid_flush, idex_flush, idex_frz, exmem_frz, memwb_frz, sram_start}
  logic [7:0] outs;
  assign outs = {bus.pc_freeze, bus.if_id_freeze, bus.if_id_flush, bus.id_ex_flush,
                 bus.id_ex_freeze, bus.ex_mem_freeze, bus.mem_wb_freeze, bus.sram_start};

  localparam logic [7:0] O_NONE  = 8'h00;
  localparam logic [7:0] O_STALL = 8'hD0;
  localparam logic [7:0] O_BR    = 8'h30;
  localparam logic [7:0] O_START = 8'hCF;
  localparam logic [7:0] O_WAIT  = 8'hCE;

  typedef struct {
    logic       fwd_en;
    logic [4:0] src1;
    logic [4:0] src2;
    logic       two_src;
    logic [4:0] exe_dest;
    logic       exe_wb_en;
    logic       exe_mem_r_en;
    logic [4:0] mem_dest;
    logic       mem_wb_en;
    logic       br_taken;
    logic [7:0] exp_out;
    int         stall;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic f, logic [4:0] s1, logic [4:0] s2, logic two,
                              logic [4:0] ed, logic ewb, logic emr, logic [4:0] md,
                              logic mwb, logic br, logic [7:0] eo, int st);
    vec_t v;
    v.fwd_en = f; v.src1 = s1; v.src2 = s2; v.two_src = two;
    v.exe_dest = ed; v.exe_wb_en = ewb; v.exe_mem_r_en = emr;
    v.mem_dest = md; v.mem_wb_en = mwb; v.br_taken = br;
    v.exp_out = eo; v.stall = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.fwd_en = 0; bus.src1 = 0; bus.src2 = 0; bus.two_src = 0;
    bus.exe_dest = 0; bus.exe_wb_en = 0; bus.exe_mem_r_en = 0;
    bus.mem_dest = 0; bus.mem_wb_en = 0; bus.mem_req = 0;
    bus.br_taken = 0; bus.sram_ready = 0;
  endtask

  task automatic apply(input vec_t v);
    bus.fwd_en = v.fwd_en; bus.src1 = v.src1; bus.src2 = v.src2;
    bus.two_src = v.two_src; bus.exe_dest = v.exe_dest; bus.exe_wb_en = v.exe_wb_en;
    bus.exe_mem_r_en = v.exe_mem_r_en; bus.mem_dest = v.mem_dest;
    bus.mem_wb_en = v.mem_wb_en; bus.br_taken = v.br_taken;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           fwd s1 s2 two ed ewb emr md mwb br  expected stall
    vecs[0]  = mk(1, 5, 0, 0, 5, 1, 1, 0, 0, 0, O_STALL, 1); // load-use
    vecs[1]  = mk(1, 5, 0, 0, 5, 1, 0, 0, 0, 0, O_NONE,  0); // ALU result forwarded
    vecs[2]  = mk(0, 1, 7, 1, 0, 0, 0, 7, 1, 0, O_STALL, 1); // MEM match on src2
    vecs[3]  = mk(0, 1, 7, 0, 0, 0, 0, 7, 1, 0, O_NONE,  0); // src2 not read
    vecs[4]  = mk(0, 0, 0, 1, 0, 1, 1, 0, 1, 0, O_NONE,  0); // r0 never hazards
    vecs[5]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, O_NONE,  0); // r0 load
    vecs[6]  = mk(0, 3, 4, 0, 3, 1, 0, 0, 0, 0, O_STALL, 1); // EXE match, no fwd
    vecs[7]  = mk(1, 5, 0, 0, 5, 1, 1, 0, 0, 1, O_BR,    0); // branch beats load-use
    vecs[8]  = mk(0, 2, 3, 1, 9, 1, 0, 8, 1, 1, O_BR,    0); // branch alone
    vecs[9]  = mk(1, 9, 0, 0, 0, 0, 0, 9, 1, 0, O_NONE,  0); // MEM forwarded
    vecs[10] = mk(0, 1, 6, 1, 6, 1, 0, 0, 0, 0, O_STALL, 1); // EXE match on src2
    vecs[11] = mk(0, 6, 1, 1, 6, 0, 1, 0, 0, 0, O_NONE,  0); // no wb_en, no fwd path

    // Reset state: outputs low even with active requests on the inputs.
    rst = 1'b0;
    clear_inputs();
    bus.mem_req = 1; bus.br_taken = 1;
    #1;
    check("reset_outs", outs, O_NONE);
    check("reset_hstall", bus.hazard_stalls, 0);
    check("reset_mstall", bus.mem_stalls, 0);
    check("reset_timeout", bus.mem_timeout, 0);
    clear_inputs();
    #11 rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      apply(vecs[i]);
      #2;
      check($sformatf("vec%0d_outs", i), outs, vecs[i].exp_out);
      tick();
      exp_haz += vecs[i].stall;
      check($sformatf("vec%0d_hstall", i), bus.hazard_stalls, exp_haz);
    end
    clear_inputs();

    // SRAM handshake: start in IDLE, ready 5 cycles later, collision mid-wait.
    bus.mem_req = 1;
    #2 check("sram_start_cycle", outs, O_START);
    tick();
    for (int c = 1; c <= 5; c++) begin
      bus.sram_ready = (c == 5);
      if (c == 3) begin
        bus.fwd_en = 1; bus.src1 = 5; bus.exe_dest = 5;
        bus.exe_mem_r_en = 1; bus.exe_wb_en = 1; bus.br_taken = 1;
      end else begin
        bus.fwd_en = 0; bus.src1 = 0; bus.exe_dest = 0;
        bus.exe_mem_r_en = 0; bus.exe_wb_en = 0; bus.br_taken = 0;
      end
      #2 check($sformatf("sram_wait%0d", c), outs, O_WAIT);
      tick();
    end
    // MEM_DONE: next instruction's mem_req must not start a new access here.
    bus.sram_ready = 0;
    #2;
    check("sram_done_outs", outs, O_NONE);
    check("sram_mstall6", bus.mem_stalls, 6);
    check("sram_hstall_kept", bus.hazard_stalls, exp_haz);
    tick();

    // Timeout: the pending request starts from IDLE, sram_ready never comes.
    #2 check("to_start", outs, O_START);
    tick();
    for (int c = 1; c <= 15; c++) begin
      #2 check($sformatf("to_wait%0d", c), outs, O_WAIT);
      if (c == 14) check("to_flag_early", bus.mem_timeout, 0);
      tick();
    end
    bus.mem_req = 0;
    #2;
    check("to_done_outs", outs, O_NONE);
    check("to_flag_set", bus.mem_timeout, 1);
    check("to_mstall_sat", bus.mem_stalls, 15);
    tick();
    bus.br_taken = 1;
    #2;
    check("to_flag_sticky", bus.mem_timeout, 1);
    check("idle_branch", outs, O_BR);
    tick();
    bus.br_taken = 0;
    check("mstall_still_sat", bus.mem_stalls, 15);

    // Async reset in the middle of MEM_WAIT.
    bus.mem_req = 1;
    tick();
    tick();
    #2 check("rst_pre_wait", outs, O_WAIT);
    rst = 1'b0;
    #1;
    check("rst_async_outs", outs, O_NONE);
    check("rst_async_flag", bus.mem_timeout, 0);
    check("rst_async_mstall", bus.mem_stalls, 0);
    check("rst_async_hstall", bus.hazard_stalls, 0);
    bus.mem_req = 0;
    tick();
    #3 rst = 1'b1;
    #1 check("rst_release_outs", outs, O_NONE);
    tick();
    bus.mem_req = 1;
    #2 check("rst_idle_start", outs, O_START);
    tick();
    bus.sram_ready = 1;
    #2 check("rst_wait", outs, O_WAIT);
    tick();
    bus.sram_ready = 0;
    bus.mem_req = 0;
    #2;
    check("rst_done_outs", outs, O_NONE);
    check("rst_mstall2", bus.mem_stalls, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
